// File: rtl/xbus_sender.sv
// xbus_sender: walks one X-buffer feature map (c innermost, then xb, then y) and streams Q-pixel packets onto the X bus.
// Reads run ahead of the bus into a 4-entry skid FIFO, so cache_full stalls never drop or repeat a packet.
module xbus_sender #(
  parameter int Q      = 8,
  parameter int S      = 16,
  parameter int P      = 8,
  parameter int ADDR_W = 16,
  parameter int TAG_W  = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         INC2_minus_1,
  input  logic [15:0]         INH2,
  input  logic [15:0]         INW2,
  input  logic [7:0]          Xz,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                x_rd_en,
  output logic [ADDR_W-1:0]   x_rd_addr,
  input  logic [Q*S*8-1:0]    x_rd_data,
  input  logic [P-1:0]        cache_full,
  output logic [TAG_W-1:0]    pkt_tag,
  output logic [Q*S*8-1:0]    pkt_data,
  output logic                busy,
  output logic                done
);

  localparam int DW = Q*S*8;
  localparam int LW = S*8;
  localparam int FW = 49;  // {last, c, y, xb}

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [15:0]       r_nc_m1;
  logic [15:0]       r_inh_m1;
  logic [15:0]       r_nxb_m1;
  logic [15:0]       r_lastv;
  logic [7:0]        r_xz;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_c;
  logic [15:0]       r_y;
  logic [15:0]       r_xb;
  logic              r_stall;
  logic              r_v1;
  logic              r_v2;
  logic [FW-1:0]     r_t1;
  logic [FW-1:0]     r_t2;
  logic [DW-1:0]     r_mem_dat [4];
  logic [FW-1:0]     r_mem_tag [4];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_count;
  logic              r_busy;
  logic              r_done;
  logic [TAG_W-1:0]  r_pkt_tag;
  logic [DW-1:0]     r_pkt_data;

  logic [16:0]       w_nxb;
  logic [15:0]       w_nxb_m1;
  logic [15:0]       w_lastv;
  logic              w_accept;
  logic              w_empty_map;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic              w_rd_last;
  logic              w_push;
  logic [DW-1:0]     w_push_dat;
  logic              w_avail;
  logic              w_pop;
  logic [DW-1:0]     w_head_dat;
  logic [FW-1:0]     w_head_tag;
  logic [2:0]        w_count_nxt;
  logic              w_fin_ok;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_empty_map = (INH2 == 16'd0) || (INW2 == 16'd0);
  assign w_nxb       = ({1'b0, INW2} + 17'(Q - 1)) / 17'(Q);
  assign w_nxb_m1    = 16'(w_nxb - 17'd1);
  // Number of real pixels in the ragged last column block (1..Q).
  assign w_lastv     = INW2 - w_nxb_m1 * 16'(Q);

  // Credit covers both FIFO occupancy and reads still inside the RAM pipeline.
  assign w_occ     = r_count + {2'b00, r_v1} + {2'b00, r_v2};
  assign w_issue   = (r_state == RUN) && (w_occ < 3'd4);
  assign w_rd_last = (r_c == r_nc_m1) && (r_xb == r_nxb_m1) && (r_y == r_inh_m1);

  assign w_push = r_v2;

  always_comb begin
    w_push_dat = x_rd_data;
    if (r_t2[15:0] == r_nxb_m1) begin
      for (int j = 0; j < Q; j++) begin
        if (16'(j) >= r_lastv) begin
          w_push_dat[j*LW +: LW] = {S{r_xz}};
        end
      end
    end
  end

  // An empty FIFO lets the arriving word fall straight through to the bus.
  always_comb begin
    if (r_count == 3'd0) begin
      w_head_dat = w_push_dat;
      w_head_tag = r_t2;
    end else begin
      w_head_dat = r_mem_dat[r_rd_ptr];
      w_head_tag = r_mem_tag[r_rd_ptr];
    end
  end

  assign w_avail     = (r_count != 3'd0) || w_push;
  assign w_pop       = w_avail && !r_stall;
  assign w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};
  assign w_fin_ok    = w_pop && w_head_tag[48] && (w_count_nxt == 3'd0) && !w_issue && !r_v1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = w_empty_map ? FIN : RUN;
      RUN:     if (w_issue && w_rd_last) w_state_nxt = DRAIN;
      DRAIN:   if (w_fin_ok) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_rd_en   = w_issue;
    x_rd_addr = w_issue ? r_addr : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nc_m1  <= '0;
      r_inh_m1 <= '0;
      r_nxb_m1 <= '0;
      r_lastv  <= '0;
      r_xz     <= '0;
      r_addr   <= '0;
      r_c      <= '0;
      r_y      <= '0;
      r_xb     <= '0;
    end else if (w_accept) begin
      r_nc_m1  <= INC2_minus_1;
      r_inh_m1 <= INH2 - 16'd1;
      r_nxb_m1 <= w_nxb_m1;
      r_lastv  <= w_lastv;
      r_xz     <= Xz;
      r_addr   <= base_addr;
      r_c      <= '0;
      r_y      <= '0;
      r_xb     <= '0;
    end else if (w_issue) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (r_c == r_nc_m1) begin
        r_c <= '0;
        if (r_xb == r_nxb_m1) begin
          r_xb <= '0;
          r_y  <= r_y + 16'd1;
        end else begin
          r_xb <= r_xb + 16'd1;
        end
      end else begin
        r_c <= r_c + 16'd1;
      end
    end
  end

  // Tag fields ride alongside the 2-cycle RAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_t1    <= '0;
      r_t2    <= '0;
      r_stall <= 1'b0;
    end else begin
      r_v1    <= w_issue;
      r_v2    <= r_v1;
      r_t1    <= {w_rd_last, r_c, r_y, r_xb};
      r_t2    <= r_t1;
      r_stall <= |cache_full;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_dat[r_wr_ptr] <= w_push_dat;
      r_mem_tag[r_wr_ptr] <= r_t2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_tag  <= '0;
      r_pkt_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_pop) begin
        r_pkt_tag  <= TAG_W'({1'b1, w_head_tag});
        r_pkt_data <= w_head_dat;
      end else begin
        r_pkt_tag  <= '0;
        r_pkt_data <= '0;
      end
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (r_state == FIN) begin
        r_busy <= 1'b0;
      end
      r_done <= (r_state == FIN);
    end
  end

  assign pkt_tag  = r_pkt_tag;
  assign pkt_data = r_pkt_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_xbus_sender.sv
// Directed bench for xbus_sender: scoreboard of packets built from the loop order, plus timing and stall checks.
module tb_xbus_sender;
  localparam int Q = 8, S = 16, P = 8, AW = 16, TW = 50;
  localparam int DW = Q*S*8, LW = S*8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [15:0] inc_m1, inh, inw;
  logic [7:0] xz;
  logic [AW-1:0] base;
  logic x_rd_en;
  logic [AW-1:0] x_rd_addr;
  logic [DW-1:0] x_rd_data;
  logic [P-1:0] cache_full;
  logic [TW-1:0] pkt_tag;
  logic [DW-1:0] pkt_data;
  logic busy, done;

  xbus_sender #(.Q(Q), .S(S), .P(P), .ADDR_W(AW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .INC2_minus_1(inc_m1), .INH2(inh), .INW2(inw),
    .Xz(xz), .base_addr(base), .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .cache_full(cache_full), .pkt_tag(pkt_tag), .pkt_data(pkt_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM model: 2-cycle read latency, contents a fixed function of the address.
  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int b = 0; b < DW/8; b++) w[b*8 +: 8] = 8'(int'(a)*37 + b*11 + 5);
    return w;
  endfunction
  logic [AW-1:0] ra1, ra2;
  always @(posedge clk) begin
    ra1 <= x_rd_addr;
    ra2 <= ra1;
  end
  assign x_rd_data = word(ra2);

  logic [48:0] eq_tag[$];
  logic [DW-1:0] eq_dat[$];
  task automatic build(input int ncm1, input int h, input int w, input int b, input logic [7:0] z);
    int nxb, n, k;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    nxb = (w + Q - 1) / Q;
    n = h * nxb * (ncm1 + 1);
    k = 0;
    eq_tag.delete();
    eq_dat.delete();
    for (int y = 0; y < h; y++)
      for (int xb = 0; xb < nxb; xb++)
        for (int c = 0; c <= ncm1; c++) begin
          a = AW'(b + k);
          d = word(a);
          for (int j = 0; j < Q; j++) if (xb*Q + j >= w) d[j*LW +: LW] = {S{z}};
          eq_tag.push_back({(k == n-1), 16'(c), 16'(y), 16'(xb)});
          eq_dat.push_back(d);
          k++;
        end
  endtask

  int cyc = 0, s0 = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic cf1 = 1'b0, cf2 = 1'b0;
  always @(posedge clk) begin
    cf1 <= |cache_full;
    cf2 <= cf1;
  end

  int rd_cnt, pkt_cnt, done_cnt, first_rd, first_pkt, last_pkt, done_cyc, max_out;
  logic [AW-1:0] rd_base, m_ea;
  logic [48:0] m_t;
  logic [DW-1:0] m_d;
  logic mon_en = 1'b0, stall_chk = 1'b0;

  always @(negedge clk) if (mon_en && !rst) begin
    if (x_rd_en) begin
      if (rd_cnt == 0) first_rd = cyc - s0;
      m_ea = rd_base + AW'(rd_cnt);
      chk("rd_addr", x_rd_addr, m_ea);
      rd_cnt++;
    end
    if (pkt_tag[49]) begin
      if (stall_chk) chk("pkt_after_stall", cf2, 0);
      if (eq_tag.size() == 0) chk("extra_pkt", 1, 0);
      else begin
        m_t = eq_tag.pop_front();
        m_d = eq_dat.pop_front();
        chk("pkt_tag", pkt_tag[48:0], m_t);
        for (int j = 0; j < Q; j++) chk("pkt_lane", pkt_data[j*LW +: LW], m_d[j*LW +: LW]);
      end
      if (pkt_cnt == 0) first_pkt = cyc - s0;
      last_pkt = cyc - s0;
      pkt_cnt++;
    end else begin
      chk("idle_tag", pkt_tag, 0);
      chk("idle_data", |pkt_data, 0);
    end
    if (rd_cnt - pkt_cnt > max_out) max_out = rd_cnt - pkt_cnt;
    if (done) begin
      done_cnt++;
      done_cyc = cyc - s0;
      chk("busy_at_done", busy, 0);
    end
  end

  task automatic go(input int ncm1, input int h, input int w, input int b, input logic [7:0] z);
    build(ncm1, h, w, b, z);
    @(negedge clk);
    inc_m1 = 16'(ncm1); inh = 16'(h); inw = 16'(w); base = AW'(b); xz = z;
    rd_base = AW'(b);
    rd_cnt = 0; pkt_cnt = 0; done_cnt = 0; max_out = 0;
    first_rd = -1; first_pkt = -1; last_pkt = -1; done_cyc = -1;
    s0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (done_cnt == 0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    rst = 1'b1; start = 1'b0; cache_full = '0;
    inc_m1 = '0; inh = '0; inw = '0; xz = '0; base = '0;
    repeat (3) @(negedge clk);
    chk("rst_pkt_tag", pkt_tag, 0);
    chk("rst_pkt_data", |pkt_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", x_rd_en, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 8-packet transfer; a second start during the run must be ignored.
    go(1, 2, 16, 'h0100, 8'h00);
    chk("busy_after_start", busy, 1);
    repeat (4) @(negedge clk);
    base = 'h3000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(60);
    chk("a_first_rd_cyc", first_rd, 1);
    chk("a_first_pkt_cyc", first_pkt, 4);
    chk("a_last_pkt_cyc", last_pkt, 11);
    chk("a_done_cyc", done_cyc, 12);
    chk("a_pkt_cnt", pkt_cnt, 8);
    chk("a_rd_cnt", rd_cnt, 8);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_left", eq_tag.size(), 0);

    // Ragged last column block padded with Xz.
    go(0, 1, 10, 'h0040, 8'h80);
    wait_done(40);
    chk("b_pkt_cnt", pkt_cnt, 2);
    chk("b_left", eq_tag.size(), 0);

    // Address wrap.
    go(0, 1, 32, 'hFFFE, 8'h11);
    wait_done(40);
    chk("w_rd_cnt", rd_cnt, 4);
    chk("w_pkt_cnt", pkt_cnt, 4);

    // Random 50% backpressure, N=64.
    stall_chk = 1'b1;
    go(7, 4, 16, 'h1000, 8'h00);
    i = 0;
    while (done_cnt == 0 && i < 2000) begin
      cache_full = ($urandom_range(0, 1) == 1) ? P'($urandom_range(1, 255)) : '0;
      @(negedge clk);
      i++;
    end
    cache_full = '0;
    if (done_cnt == 0) chk("r_done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    chk("r_pkt_cnt", pkt_cnt, 64);
    chk("r_left", eq_tag.size(), 0);
    chk("r_max_out_le4", max_out <= 4, 1);

    // Held backpressure: reads stop at the credit limit, then resume at full rate.
    cache_full = 8'h04;
    repeat (2) @(negedge clk);
    go(7, 1, 16, 'h2000, 8'h00);
    repeat (20) @(negedge clk);
    chk("h_rd_cnt", rd_cnt, 4);
    chk("h_pkt_cnt", pkt_cnt, 0);
    cache_full = '0;
    wait_done(100);
    chk("h_pkt_total", pkt_cnt, 16);
    chk("h_burst_len", last_pkt - first_pkt, 15);
    chk("h_max_out_le4", max_out <= 4, 1);
    chk("h_left", eq_tag.size(), 0);
    stall_chk = 1'b0;

    // Empty map: no reads, done at cycle 2; a start while busy is ignored.
    go(0, 0, 16, 'h0000, 8'h00);
    chk("e_busy", busy, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    repeat (5) @(negedge clk);
    chk("e_done_cyc", done_cyc, 2);
    chk("e_rd_cnt", rd_cnt, 0);
    chk("e_done_cnt", done_cnt, 1);

    // Reset mid-transfer, then a clean restart.
    go(7, 4, 16, 'h0500, 8'h00);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    rd_cnt = 0;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("x_no_done", done_cnt, 0);
    chk("x_no_reads", rd_cnt, 0);
    chk("x_busy", busy, 0);
    go(0, 2, 16, 'h0200, 8'h00);
    wait_done(40);
    chk("x_first_rd_cyc", first_rd, 1);
    chk("x_pkt_cnt", pkt_cnt, 4);
    chk("x_rd_cnt", rd_cnt, 4);
    chk("x_left", eq_tag.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
